// File: rtl/logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe_if
// Purpose : Groups the operand/op handshake, the result handshake and the
//           accepted-operation counter of logic_unit_pipe into one bundle.
// Signals : in_a, in_b, op, in_valid -> unit      in_ready      <- unit
//           out_z, out_valid, op_count <- unit    out_ready     -> unit
//           out_reduce <- unit (only with LOGIC_UNIT_PIPE_REDUCE_EN defined)
// Modports: master = producer/consumer side (testbench or upstream logic)
//           slave  = the logic unit itself
// -----------------------------------------------------------------------------
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      op_count;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  logic             out_reduce;
`endif

  modport master (
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    input  out_reduce,
`endif
    output in_a, in_b, op, in_valid, out_ready,
    input  in_ready, out_z, out_valid, op_count
  );

  modport slave (
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    output out_reduce,
`endif
    input  in_a, in_b, op, in_valid, out_ready,
    output in_ready, out_z, out_valid, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Purpose : Bitwise logic unit (OR/AND/NAND/NOR/XOR/XNOR/NOT A/pass A) whose
//           results are written into a small output FIFO on acceptance and
//           drained with a valid/ready handshake. Counts accepted operations.
// Ports   : clk    - sole clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - logic_unit_pipe_if.slave (operands, op, handshakes,
//                    out_z, op_count, optional out_reduce)
// Params  : WIDTH  - operand/result width (1..32)
//           DEPTH  - output buffer entries (2 or 4)
// Option  : LOGIC_UNIT_PIPE_REDUCE_EN - adds out_reduce, the OR-reduction of
//           each result, stored alongside it in the FIFO.
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_unit_pipe_if.slave    bus
);

  // DEPTH is 2 or 4, so pointers wrap naturally at their bit width.
  localparam int         PW       = (DEPTH > 2) ? 2 : 1;
  localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

  function automatic logic [WIDTH-1:0] f_logic(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [2:0]       sel
  );
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = a | b;
      3'b001:  r = a & b;
      3'b010:  r = ~(a & b);
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] r_mem [DEPTH];
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  logic             r_red_mem [DEPTH];
`endif
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic [15:0]      r_op_count;
  // Goes high on the first clock after reset release; keeps in_ready low
  // until then so nothing is accepted in the reset-release cycle.
  logic             r_live;

  logic             w_push;
  logic             w_pop;
  logic             w_nonempty;
  logic [WIDTH-1:0] w_result;

  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & bus.out_ready;
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign bus.in_ready = r_live & ((r_count != CNT_FULL) | w_pop);
  assign w_push     = bus.in_valid & bus.in_ready;
  assign w_result   = f_logic(bus.in_a, bus.in_b, bus.op);

  assign bus.out_valid = w_nonempty;
  assign bus.out_z     = w_nonempty ? r_mem[r_rptr] : '0;
  assign bus.op_count  = r_op_count;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
  assign bus.out_reduce = w_nonempty ? r_red_mem[r_rptr] : 1'b0;
`endif

  // Control: pointers, occupancy, counter, post-reset enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_op_count <= '0;
      r_live     <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wptr     <= r_wptr + PW'(1);
        r_op_count <= r_op_count + 16'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result storage: data only, gated at the output by occupancy
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_result;
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
      r_red_mem[r_wptr] <= |w_result;
`endif
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [WIDTH:0] sb_q [$];   // {reduce, z}

  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_logic(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] sel);
    unique case (sel)
      3'd0: m_logic = a | b;
      3'd1: m_logic = a & b;
      3'd2: m_logic = ~(a & b);
      3'd3: m_logic = ~(a | b);
      3'd4: m_logic = a ^ b;
      3'd5: m_logic = ~(a ^ b);
      3'd6: m_logic = ~a;
      3'd7: m_logic = a;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && bus.out_valid; k++) step();
    check("drain", 32'(bus.out_valid), 32'd0);
  endtask

  // Scoreboard: compare the head on a pop first, then record a new push.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'(bus.out_z), 32'hDEAD);
        end else begin
          logic [WIDTH:0] e;
          e = sb_q.pop_front();
          check("sb_z", 32'(bus.out_z), 32'(e[WIDTH-1:0]));
`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
          check("sb_reduce", 32'(bus.out_reduce), 32'(e[WIDTH]));
`endif
        end
      end
      if (!bus.out_valid) begin
        check("z_idle", 32'(bus.out_z), 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        logic [WIDTH-1:0] z;
        z = m_logic(bus.in_a, bus.in_b, bus.op);
        sb_q.push_back({|z, z});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]       tt_exp [8];
    logic [WIDTH-1:0] exp_first;
    n_tests = 0;
    n_fail  = 0;
    tt_exp = '{8'hFC, 8'hC0, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.op = 3'd0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_z", 32'(bus.out_z), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check("rdy_before_edge", 32'(bus.in_ready), 32'd0);
    step();
    check("rdy_after_edge", 32'(bus.in_ready), 32'd1);

    // Truth table, back-to-back
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 8'hF0;
    bus.in_b = 8'hCC;
    for (int i = 0; i < 8; i++) begin
      bus.op = 3'(i);
      step();
      check("tt_z", 32'(bus.out_z), 32'(tt_exp[i]));
      check("tt_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    check("tt_op_count", 32'(bus.op_count), 32'd8);
    wait_drain();

    // Backpressure with a full buffer
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 8'h5A; bus.in_b = 8'h3C; bus.op = 3'd4;
    exp_first = m_logic(8'h5A, 8'h3C, 3'd4);
    step();
    bus.in_a = 8'hA7; bus.in_b = 8'h19; bus.op = 3'd1;
    step();
    bus.in_a = 8'h81; bus.in_b = 8'h7E; bus.op = 3'd3;
    check("bp_full_rdy", 32'(bus.in_ready), 32'd0);
    check("bp_head", 32'(bus.out_z), 32'(exp_first));
    step();
    check("bp_full_rdy2", 32'(bus.in_ready), 32'd0);
    check("bp_head_hold", 32'(bus.out_z), 32'(exp_first));
    bus.out_ready = 1'b1;
    #1 check("bp_rdy_on_pop", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    wait_drain();
    check("bp_op_count", 32'(bus.op_count), 32'd11);

    // Simultaneous push and pop at occupancy 1
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.op = 3'($urandom);
    step();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.op = 3'($urandom);
      step();
      check("ss_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    check("ss_empty", 32'(bus.out_valid), 32'd0);
    check("ss_op_count", 32'(bus.op_count), 32'd22);

    // Reset mid-stream with two entries buffered
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = 8'h33; bus.in_b = 8'h0F; bus.op = 3'd0;
    step();
    bus.op = 3'd5;
    step();
    bus.in_valid = 1'b0;
    check("mid_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_z", 32'(bus.out_z), 32'd0);
    check("mid_rst_count", 32'(bus.op_count), 32'd0);
    check("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
    sb_q.delete();
    step();
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("mid_rel_rdy", 32'(bus.in_ready), 32'd0);
    step();
    check("mid_rdy", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Counter wrap
    bus.in_valid = 1'b1;
    bus.op = 3'd5;
    for (int k = 0; k < 65535; k++) begin
      bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    check("wrap_ffff", 32'(bus.op_count), 32'hFFFF);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("wrap_zero", 32'(bus.op_count), 32'h0);
    wait_drain();

`ifdef LOGIC_UNIT_PIPE_REDUCE_EN
    bus.in_valid = 1'b1;
    bus.in_a = 8'h0F; bus.in_b = 8'hF0; bus.op = 3'd1;
    step();
    check("red_and_z", 32'(bus.out_z), 32'h00);
    check("red_and_r", 32'(bus.out_reduce), 32'd0);
    bus.op = 3'd0;
    step();
    bus.in_valid = 1'b0;
    check("red_or_z", 32'(bus.out_z), 32'hFF);
    check("red_or_r", 32'(bus.out_reduce), 32'd1);
    wait_drain();
    check("red_idle", 32'(bus.out_reduce), 32'd0);
`endif

    step();
    check("sb_left", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal 1..32).
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries (legal 2 or 4).
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_a, input, WIDTH, operand A.
REQ-006 SHALL have port in_b, input, WIDTH, operand B.
REQ-007 SHALL have port op, input, 3, operation select; sampled with in_a/in_b.
REQ-008 SHALL have port in_valid, input, 1, operand/op valid.
REQ-009 SHALL have port in_ready, output, 1, unit accepts the operation this cycle.
REQ-010 SHALL have port out_z, output, WIDTH, result at buffer head.
REQ-011 SHALL have port out_valid, output, 1, out_z valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts out_z.
REQ-013 SHALL have port op_count, output, 16, number of accepted operations.

Function
REQ-014 SHALL compute bitwise: 000 OR, 001 AND, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 pass A (in_b ignored for 110/111).
REQ-015 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1; the result is written to the output FIFO on that edge.
REQ-016 SHALL present an accepted result on out_z with out_valid=1 in the cycle after acceptance (latency 1) when the buffer was empty.
REQ-017 SHALL pop the head entry on a rising edge where out_valid and out_ready are both 1.
REQ-018 SHALL drive out_valid=1 when occupancy > 0 and in_ready=1 when occupancy < DEPTH or a pop occurs in the same cycle.
REQ-019 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve FIFO order.
REQ-020 SHALL, when full with out_ready=0, hold in_ready=0, hold out_z stable, and drop nothing.
REQ-021 SHALL keep out_z stable while out_valid=1 and out_ready=0.
REQ-022 SHALL wrap read/write pointers modulo DEPTH with no bubble at the wrap.
REQ-023 SHALL ignore in_a, in_b and op when no acceptance occurs.
REQ-024 SHALL increment op_count by 1 per acceptance, wrapping 16'hFFFF to 0.
REQ-025 SHALL drive out_z to 0 when out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, force immediately: occupancy 0, pointers 0, out_valid=0, out_z=0, op_count=0, in_ready=0.
REQ-027 SHALL discard all buffered results if reset asserts mid-operation; nothing emerges after release.
REQ-028 SHALL raise in_ready on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with LOGIC_UNIT_PIPE_REDUCE_EN defined, add output out_reduce (1 bit) = OR-reduction of out_z, stored per FIFO entry, valid with out_valid, 0 in reset and when empty.
REQ-030 SHALL, without LOGIC_UNIT_PIPE_REDUCE_EN, omit port out_reduce and its storage; all other behaviour identical.

Verification
REQ-031 Truth table: WIDTH=8, in_a=8'hF0, in_b=8'hCC, op 000..111 back-to-back, out_ready=1 -> out_z FC,C0,3F,03,3C,C3,0F,F0 each one cycle after acceptance; op_count=8.
REQ-032 Backpressure: DEPTH=2, out_ready=0, push 3 ops -> first 2 accepted, in_ready=0 on third, out_z holds first result; raise out_ready -> results emerge in order, third then accepted.
REQ-033 Simultaneous push/pop: buffer holding 1 entry, in_valid=1 and out_ready=1 for 10 cycles -> occupancy stays 1, 10 results in order, no gaps.
REQ-034 Reset mid-stream: 2 entries buffered, pulse rst_n low between edges -> out_valid=0, out_z=0, op_count=0 immediately; no stale result after release.
REQ-035 Counter wrap: force 65535 acceptances then 1 more -> op_count 16'hFFFF then 16'h0000.
REQ-036 Reduce option (macro defined): op 001 with in_a=8'h0F, in_b=8'hF0 -> out_z=00, out_reduce=0; op 000 same operands -> out_z=FF, out_reduce=1.
